// File: rtl/cdb_arbiter_if.sv
// Result-collection / common-data-bus bundle between the functional units and cdb_arbiter.
// The master modport is the arbiter side; the slave modport is the functional-unit side.
interface cdb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N_SRC      = 4,
    parameter int RS_ID_W    = 3
);
    logic [N_SRC-1:0]            src_valid;
    logic [N_SRC*DATA_WIDTH-1:0] src_result;
    logic [N_SRC*RS_ID_W-1:0]    src_rs_id;
    logic [N_SRC-1:0]            retire;
    logic                        cdb_valid;
    logic [DATA_WIDTH-1:0]       cdb_result;
    logic [RS_ID_W-1:0]          cdb_rs_id;
    logic                        busy;

    modport master (
        input  src_valid, src_result, src_rs_id,
        output retire, cdb_valid, cdb_result, cdb_rs_id, busy
    );

    modport slave (
        output src_valid, src_result, src_rs_id,
        input  retire, cdb_valid, cdb_result, cdb_rs_id, busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter broadcasting one functional-unit result per cycle on the CDB.
// Optional CDB_ARB_STATS_EN adds saturating broadcast/conflict counters.
module cdb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int N_SRC      = 4,
    parameter int RS_ID_W    = 3
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.master cdb
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]   stat_broadcasts_o,
    output logic [31:0]   stat_conflicts_o
`endif
);
    localparam int PTR_W = $clog2(N_SRC);
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(N_SRC - 1);

    logic [DATA_WIDTH-1:0] src_res_arr [N_SRC];
    logic [RS_ID_W-1:0]    src_id_arr  [N_SRC];

    logic [N_SRC-1:0]      retire_q, retire_d;
    logic                  cdb_valid_q;
    logic [DATA_WIDTH-1:0] cdb_result_q;
    logic [RS_ID_W-1:0]    cdb_rs_id_q;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [N_SRC-1:0]      elig;
    logic                  grant;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      cand;
    int                    scan_idx;
    logic                  busy;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_res_arr[i] = cdb.src_result[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_id_arr[i]  = cdb.src_rs_id[i*RS_ID_W +: RS_ID_W];
    end

    // A source retired this cycle still shows its old result, so it is masked out.
    assign elig = cdb.src_valid & ~retire_q;

    always_comb begin
        grant    = 1'b0;
        win      = '0;
        cand     = '0;
        scan_idx = 0;
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_SRC) scan_idx = scan_idx - N_SRC;
            cand = scan_idx[PTR_W-1:0];
            if (!grant && elig[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
        retire_d = grant ? (N_SRC'(1) << win) : '0;
        rr_ptr_d = rr_ptr_q;
        if (grant) rr_ptr_d = (win == LAST_SRC) ? '0 : win + 1'b1;
    end

    assign busy = rst && ($countones(elig) > 1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_result_q <= '0;
            cdb_rs_id_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            retire_q    <= retire_d;
            cdb_valid_q <= grant;
            rr_ptr_q    <= rr_ptr_d;
            if (grant) begin
                cdb_result_q <= src_res_arr[win];
                cdb_rs_id_q  <= src_id_arr[win];
            end
        end
    end

    assign cdb.retire     = retire_q;
    assign cdb.cdb_valid  = cdb_valid_q;
    assign cdb.cdb_result = cdb_result_q;
    assign cdb.cdb_rs_id  = cdb_rs_id_q;
    assign cdb.busy       = busy;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] stat_bcast_q, stat_conf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bcast_q <= '0;
            stat_conf_q  <= '0;
        end else begin
            if (grant && stat_bcast_q != '1) stat_bcast_q <= stat_bcast_q + 32'd1;
            if (busy && stat_conf_q != '1)   stat_conf_q  <= stat_conf_q + 32'd1;
        end
    end

    assign stat_broadcasts_o = stat_bcast_q;
    assign stat_conflicts_o  = stat_conf_q;
`endif
endmodule
